// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks a 10-bit PC, reads one word at a time from memory
// and hands it to the decoder over valid/ready. Optional watchdog under FETCH_TIMEOUT_EN.
module inst_fetch #(
  parameter logic [9:0] RESET_PC       = 10'h000,
  parameter logic [4:0] HALT_OPCODE    = 5'h1F,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pc_load,
  input  logic [9:0]  pc_load_addr,
  input  logic        ins_ready,
  output logic        mem_req,
  output logic [9:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] ins,
  output logic        ins_valid,
  output logic [9:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_t;

  state_t state;
  logic   squash;
  logic   timed_out;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  assign fault     = fault_q;
  assign timed_out = (state == WAIT) && !mem_rvalid && (wait_cnt == CNT_LAST);

  // Counts consecutive silent WAIT cycles; any other state clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (timed_out) fault_q <= 1'b1;
      if (state == WAIT && !mem_rvalid) wait_cnt <= wait_cnt + 1'b1;
      else                              wait_cnt <= '0;
    end
  end
`else
  assign fault     = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ins       <= '0;
      ins_valid <= 1'b0;
      squash    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_load) pc <= pc_load_addr;
          else if (start) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          // The request is already on the bus; its response must be thrown away.
          if (pc_load) begin
            pc     <= pc_load_addr;
            squash <= 1'b1;
          end
        end
        WAIT: begin
          if (timed_out) begin
            state     <= HALT;
            busy      <= 1'b0;
            halted    <= 1'b1;
            ins_valid <= 1'b0;
            squash    <= 1'b0;
          end else if (pc_load) begin
            pc <= pc_load_addr;
            if (mem_rvalid) begin
              squash   <= 1'b0;
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc_load_addr;
            end else begin
              squash <= 1'b1;
            end
          end else if (mem_rvalid) begin
            if (squash) begin
              squash   <= 1'b0;
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end else begin
              ins       <= mem_rdata;
              ins_valid <= 1'b1;
              pc        <= pc + 10'd1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (pc_load) begin
            ins_valid <= 1'b0;
            pc        <= pc_load_addr;
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= pc_load_addr;
          end else if (ins_ready) begin
            ins_valid <= 1'b0;
            if (ins[14:10] == HALT_OPCODE) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end
          end
        end
        HALT: begin
          // A watchdog fault pins the unit here until reset.
          if (pc_load && !fault) begin
            pc       <= pc_load_addr;
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc_load_addr;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: the bench plays instruction memory and checks the fetched
// stream against address arithmetic (sequential PC, jumps, wrap, halt).
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, pc_load, ins_ready;
  logic [9:0]  pc_load_addr, mem_addr, pc;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rvalid = 1'b0;
  logic [15:0] ins;
  logic        mem_req, ins_valid, busy, halted, fault;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(10'h000), .HALT_OPCODE(5'h1F), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .ins_ready(ins_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ins(ins), .ins_valid(ins_valid), .pc(pc), .busy(busy), .halted(halted),
    .fault(fault));

  logic [15:0] mem [1024];
  logic [9:0]  req_q[$], pc_q[$];
  logic [15:0] got_q[$];
  int          req_count = 0, valid_cycles = 0;
  bit          ffff_seen = 0;
  logic [9:0]  last_req = '0;
  int          lat = 2;
  bit          lat_rand = 0, no_resp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and bus monitor, sampled mid-cycle.
  initial begin
    bit         pending = 0, prev_req = 0;
    int         cnt = 0;
    logic [9:0] pend_addr = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        pending  = 0;
        prev_req = 0;
      end else begin
        if (mem_req) begin
          chk("req_single_cycle", 32'(prev_req), 0);
          chk("one_outstanding", 32'(pending), 0);
        end
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[pend_addr];
            pending    = 0;
          end
        end
        if (mem_req) begin
          req_q.push_back(mem_addr);
          req_count++;
          last_req = mem_addr;
          if (!no_resp) begin
            pending   = 1;
            pend_addr = mem_addr;
            cnt       = lat_rand ? int'($urandom_range(1, 4)) : lat;
          end
        end
        if (ins_valid) valid_cycles++;
        if (ins_valid && ins == 16'hFFFF) ffff_seen = 1;
        if (ins_valid && ins_ready && !pc_load) begin
          got_q.push_back(ins);
          pc_q.push_back(pc);
        end
        prev_req = mem_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    req_q.delete();
    got_q.delete();
    pc_q.delete();
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got_q.size() < n && k < 2000) begin tick(); k++; end
    chk(tag, 32'(got_q.size() >= n), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!ins_valid && k < 200) begin tick(); k++; end
    chk(tag, 32'(ins_valid), 1);
  endtask

  task automatic jump(input logic [9:0] addr);
    pc_load      = 1'b1;
    pc_load_addr = addr;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    int         rc, k, n;
    logic [9:0] p, a;
    logic [15:0] w;
    rst_n = 1'b0; start = 1'b0; pc_load = 1'b0; pc_load_addr = '0; ins_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0C00 | 16'(i);

    // Reset state
    tick(); tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_ins", 32'(ins), 0);
    chk("rst_ins_valid", 32'(ins_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    tick();

    // Two sequential words, latency 2, consumer always ready
    mem[0] = 16'h0401; mem[1] = 16'h0802; mem[2] = 16'h1234;
    lat = 2; ins_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    wait_got(2, "two_words_timeout");
    ins_ready = 1'b0;
    chk("req0_addr", 32'(req_q[0]), 0);
    chk("req1_addr", 32'(req_q[1]), 1);
    chk("word0", 32'(got_q[0]), 32'h0401);
    chk("word1", 32'(got_q[1]), 32'h0802);
    chk("pc_after_word0", 32'(pc_q[0]), 1);
    chk("pc_after_word1", 32'(pc_q[1]), 2);
    chk("valid_one_cycle_each", 32'(valid_cycles), 2);

    // Back-pressure: word held stable, no new requests
    wait_valid("stall_word_timeout");
    rc = req_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ins", 32'(ins), 32'h1234);
      chk("stall_valid", 32'(ins_valid), 1);
      chk("stall_no_req", 32'(mem_req), 0);
    end
    chk("stall_req_count", 32'(req_count), 32'(rc));

    // Release, then jump while waiting on address 5 whose data must be dropped
    mem[5] = 16'hFFFF; mem[10'h200] = 16'h1111; mem[10'h201] = 16'h2222;
    clear_q();
    lat = 6; ins_ready = 1'b1;
    k = 0;
    while (req_q.size() == 0 && k < 100) begin tick(); k++; end
    chk("next_req_after_stall", 32'(req_q[0]), 3);
    k = 0;
    while (last_req != 10'd5 && k < 200) begin tick(); k++; end
    chk("reached_addr5", 32'(last_req), 5);
    tick();
    clear_q();
    jump(10'h200);
    wait_got(1, "jump_word_timeout");
    ins_ready = 1'b0;
    chk("jump_req_addr", 32'(req_q[0]), 32'h200);
    chk("jump_word", 32'(got_q[0]), 32'h1111);
    chk("jump_pc", 32'(pc_q[0]), 32'h201);
    chk("squashed_never_shown", 32'(ffff_seen), 0);
    lat = 2;

    // Jump from OUT (word discarded even with ready) to 1023, then wrap
    wait_valid("word_201_timeout");
    mem[1023] = 16'h0000;
    clear_q();
    ins_ready = 1'b1;
    jump(10'd1023);
    wait_got(1, "wrap_word_timeout");
    ins_ready = 1'b0;
    chk("wrap_req_addr", 32'(req_q[0]), 1023);
    chk("wrap_word", 32'(got_q[0]), 0);
    chk("wrap_pc", 32'(pc_q[0]), 0);

    // Halt opcode
    wait_valid("word_0_timeout");
    mem[10'h050] = 16'h7C00;
    clear_q();
    ins_ready = 1'b1;
    jump(10'h050);
    k = 0;
    while (!halted && k < 100) begin tick(); k++; end
    chk("halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_word", 32'(got_q[0]), 32'h7C00);
    chk("halt_pc", 32'(pc), 32'h051);
    rc = req_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("halt_no_req", 32'(req_count), 32'(rc));
    chk("halt_start_ignored", 32'(halted), 1);
    clear_q();
    jump(10'h010);
    chk("resume_busy", 32'(busy), 1);
    wait_got(1, "resume_timeout");
    ins_ready = 1'b0;
    chk("resume_req_addr", 32'(req_q[0]), 32'h010);
    chk("resume_word", 32'(got_q[0]), 32'h0C10);
    chk("resume_not_halted", 32'(halted), 0);

    // Reset aborts a held word
    wait_valid("word_11_timeout");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(ins_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pc", 32'(pc), 0);

    // Randomized run: random words, latencies and back-pressure
    for (int i = 0; i < 1024; i++) begin
      w = 16'($urandom);
      if (w[14:10] == 5'h1F) w[14:10] = 5'h00;
      mem[i] = w;
    end
    p = 10'(1000 + $urandom_range(0, 23));
    pc_load = 1'b1; pc_load_addr = p; start = 1'b1;
    tick();
    pc_load = 1'b0; start = 1'b0;
    chk("pc_load_over_start_idle", 32'(busy), 0);
    chk("idle_pc_load", 32'(pc), 32'(p));
    clear_q();
    lat_rand = 1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 40; k = 0;
    while (got_q.size() < n && k < 3000) begin
      ins_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    ins_ready = 1'b0;
    chk("rand_count", 32'(got_q.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      a = 10'(p + 10'(i));
      chk("rand_req_addr", 32'(req_q[i]), 32'(a));
      chk("rand_word", 32'(got_q[i]), 32'(mem[a]));
      chk("rand_pc", 32'(pc_q[i]), 32'(10'(a + 10'd1)));
    end
    lat_rand = 0;

`ifdef FETCH_TIMEOUT_EN
    // Silent memory trips the watchdog after 16 WAIT cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    no_resp = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_req", 32'(mem_req), 1);
    n = 0;
    while (!fault && n < 40) begin tick(); n++; end
    chk("to_cycles", 32'(n), 17);
    chk("to_fault", 32'(fault), 1);
    chk("to_halted", 32'(halted), 1);
    rc = req_count;
    jump(10'h033);
    tick(); tick(); tick();
    chk("to_pc_load_ignored", 32'(pc), 0);
    chk("to_still_halted", 32'(halted), 1);
    chk("to_no_req", 32'(req_count), 32'(rc));
    chk("to_fault_sticky", 32'(fault), 1);
    no_resp = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("to_reset_clears", 32'(fault), 0);
    chk("to_reset_halted", 32'(halted), 0);
`else
    chk("fault_tied_low", 32'(fault), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
